cipher: RTL and testbench

CIPHER -- requirements
Module: cipher

---
 rtl/aes_pkg.sv | 55 +++++
 rtl/aes_round.sv | 52 +++++
 rtl/cipher.sv | 70 +++++++
 tb/tb_cipher.sv | 133 +++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants and byte/word helpers used by the cipher pipeline.
// Blocks are [0:127] vectors: bit 0 is the MSB and byte i sits in bits [8i:8i+7].
package aes_pkg;

  localparam int NKB = 128;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One state column, row 0 in the leftmost byte.
  function automatic logic [0:31] mix_column(input logic [0:31] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[0:7];
    a1 = c[8:15];
    a2 = c[16:23];
    a3 = c[24:31];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [0:31] rot_word(input logic [0:31] w);
    return {w[8:31], w[0:7]};
  endfunction

  function automatic logic [0:31] sub_word(input logic [0:31] w);
    return {SBOX[w[0:7]], SBOX[w[8:15]], SBOX[w[16:23]], SBOX[w[24:31]]};
  endfunction

endpackage

// File: rtl/aes_round.sv
// One registered AES round: SubBytes, ShiftRows, optional MixColumns and
// AddRoundKey, with the round key derived from the previous stage's key.
module aes_round
  import aes_pkg::*;
#(
  parameter int ROUND = 1,
  parameter bit FINAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [0:NKB-1]   state_in,
  input  logic [0:NKB-1]   key_in,
  output logic [0:NKB-1]   state_out,
  output logic [0:NKB-1]   key_out
);

  logic [0:NKB-1] sb, sr, mc, nk;
  logic [0:31]    temp;

  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign sb[8*i +: 8] = SBOX[state_in[8*i +: 8]];
  end

  // Row r of column c takes the byte from column (c+r) mod 4.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[8*(4*c+r) +: 8] = sb[8*(4*((c+r)%4)+r) +: 8];
    end
    if (FINAL) begin : g_nomix
      assign mc[32*c +: 32] = sr[32*c +: 32];
    end else begin : g_mix
      assign mc[32*c +: 32] = mix_column(sr[32*c +: 32]);
    end
  end

  assign temp = sub_word(rot_word(key_in[96 +: 32])) ^ {RCON[ROUND-1], 24'h000000};
  assign nk[0 +: 32]  = key_in[0 +: 32]  ^ temp;
  assign nk[32 +: 32] = key_in[32 +: 32] ^ nk[0 +: 32];
  assign nk[64 +: 32] = key_in[64 +: 32] ^ nk[32 +: 32];
  assign nk[96 +: 32] = key_in[96 +: 32] ^ nk[64 +: 32];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_out <= '0;
      key_out   <= '0;
    end else begin
      state_out <= mc ^ nk;
      key_out   <= nk;
    end
  end

endmodule

// File: rtl/cipher.sv
// Fully unrolled AES-128 encryption pipeline: one block per clock, 11-clock
// latency, each block carries its own key so keys may change every cycle.
module cipher
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [0:Nk*32-1] in,
  input  logic [0:Nk*32-1] key,
  output logic [0:Nk*32-1] out,
  output logic             valid_out
);

  localparam int Nkb = Nk * 32;

  // Handshake: valid_in qualifies in/key at a rising edge; there is no ready,
  // every cycle is accepted. valid_out qualifies out; out is don't-care otherwise.

  logic [0:Nkb-1] st [0:Nr];
  logic [0:Nkb-1] rk [0:Nr-1];
  logic [0:Nkb-1] s0, k0;
  logic [0:Nkb-1] unused_last_key;
  logic [0:Nr]    vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0        <= '0;
      k0        <= '0;
      vld       <= '0;
      out       <= '0;
      valid_out <= 1'b0;
    end else begin
      s0        <= in ^ key;
      k0        <= key;
      vld       <= {valid_in, vld[0:Nr-1]};
      out       <= st[Nr];
      valid_out <= vld[Nr];
    end
  end

  assign st[0] = s0;
  assign rk[0] = k0;

  for (genvar r = 1; r <= Nr; r++) begin : g_round
    if (r == Nr) begin : g_last
      aes_round #(.ROUND(r), .FINAL(1'b1)) u_round (
        .clk       (clk),
        .rst       (rst),
        .state_in  (st[r-1]),
        .key_in    (rk[r-1]),
        .state_out (st[r]),
        .key_out   (unused_last_key)
      );
    end else begin : g_mid
      aes_round #(.ROUND(r), .FINAL(1'b0)) u_round (
        .clk       (clk),
        .rst       (rst),
        .state_in  (st[r-1]),
        .key_in    (rk[r-1]),
        .state_out (st[r]),
        .key_out   (rk[r])
      );
    end
  end

endmodule

// File: tb/tb_cipher.sv
// Directed bench for cipher: FIPS-197 vectors, back-to-back, per-block keys,
// valid gaps and mid-stream reset, checked against an 11-clock expected queue.
module tb_cipher;

  localparam int LAT = 11;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_in;
  logic [0:127] in_blk, key_blk, out_blk;
  logic         valid_out;

  int checks   = 0;
  int failures = 0;

  // bit 128 = expected valid, bits 127:0 = expected ciphertext
  logic [128:0] exp_q[$];

  localparam logic [0:127] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] P_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] P_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;

  cipher #(.Nk(4), .Nr(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .in        (in_blk),
    .key       (key_blk),
    .out       (out_blk),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  task automatic prefill();
    exp_q.delete();
    for (int i = 0; i < LAT; i++) exp_q.push_back('0);
  endtask

  // Drive one cycle at the negedge, then check the output slot that is due.
  task automatic step(input logic v, input logic [0:127] d, input logic [0:127] k,
                      input logic [0:127] e, input string tag);
    logic [128:0] x;
    rst      = 1'b0;
    valid_in = v;
    in_blk   = d;
    key_blk  = k;
    exp_q.push_back({v, e});
    @(negedge clk);
    if (exp_q.size() > LAT) begin
      x = exp_q.pop_front();
      checks++;
      assert (valid_out === x[128]) else begin
        failures++;
        $error("FAIL %s valid_out: observed=%b expected=%b", tag, valid_out, x[128]);
      end
      if (x[128]) begin
        checks++;
        assert (out_blk === x[127:0]) else begin
          failures++;
          $error("FAIL %s out: observed=%h expected=%h", tag, out_blk, x[127:0]);
        end
      end
    end
  endtask

  task automatic reset_check(input string tag);
    checks++;
    assert (valid_out === 1'b0) else begin
      failures++;
      $error("FAIL %s valid_out: observed=%b expected=0", tag, valid_out);
    end
    checks++;
    assert (out_blk === 128'h0) else begin
      failures++;
      $error("FAIL %s out: observed=%h expected=0", tag, out_blk);
    end
  endtask

  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    in_blk   = '0;
    key_blk  = '0;
    repeat (3) @(negedge clk);
    reset_check("reset");
    prefill();

    // First cycle out of reset carries a real block.
    step(1'b1, P_C1, K_C1, C_C1, "c1");
    step(1'b0, '0, '0, '0, "idle");
    step(1'b1, P_B, K_B, C_B, "fips_b");
    step(1'b0, '0, '0, '0, "idle");

    step(1'b1, 128'h000102030405060708090a0b0c0d0e0f, K_C1,
         128'h0a940bb5416ef045f1c39458c653ea5a, "b2b0");
    step(1'b1, 128'h0f0e0d0c0b0a09080706050403020100, K_C1,
         128'h20a9f992b44c5be8041ffcdc6cae996a, "b2b1");
    step(1'b1, 128'h00000101030307070f0f1f1f3f3f7f7f, K_C1,
         128'hb7ea90af536c82a8c8df97106b978f5a, "b2b2");
    step(1'b1, 128'h0, K_C1,
         128'hc6a13b37878f5b826f4f8162a1c8d879, "b2b3");

    step(1'b1, P_C1, K_C1, C_C1, "alt0");
    step(1'b1, P_B,  K_B,  C_B,  "alt1");
    step(1'b1, P_C1, K_C1, C_C1, "alt2");
    step(1'b1, P_B,  K_B,  C_B,  "alt3");

    step(1'b1, P_B,  K_B,  C_B,  "gap0");
    step(1'b0, P_C1, K_C1, '0,   "gap1");
    step(1'b1, P_C1, K_C1, C_C1, "gap2");

    for (int i = 0; i < LAT; i++) step(1'b0, '0, '0, '0, "drain");

    // Five blocks in flight, then reset must discard them all.
    for (int i = 0; i < 5; i++) step(1'b1, P_C1, K_C1, C_C1, "pre_rst");
    rst      = 1'b1;
    valid_in = 1'b1;
    @(negedge clk);
    reset_check("mid_reset");
    prefill();
    for (int i = 0; i < LAT + 2; i++) step(1'b0, P_B, K_B, '0, "post_rst");
    step(1'b1, P_B, K_B, C_B, "recover");
    for (int i = 0; i < LAT; i++) step(1'b0, '0, '0, '0, "final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
